// File: rtl/aes_display_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// A three-digit BCD value (0..999) needs a 10-bit binary result.
package aes_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 3;
    localparam int CONV_ITERS = 10;
    localparam int BIN_W      = 10;

    // True when any nibble of a packed BCD word is not a decimal digit.
    function automatic logic digits_invalid(input logic [4*BCD_DIGITS-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// One BCD nibble correction for reverse double-dabble: after a right
// shift, a nibble of 8 or more must have 3 subtracted from it.
module bcd_nibble_adjust (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential three-digit BCD to binary converter (reverse double-dabble).
// One shift per cycle for ten cycles; digits above 9 short-circuit to an
// invalid result. Results hold from done until the next conversion ends.
module bcd_to_binary_seq #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       units,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] data,
    output logic             overflow,
    output logic             invalid
);

    import aes_display_pkg::*;

    localparam int          BCD_W     = 4 * BCD_DIGITS;
    localparam logic [3:0]  LAST_ITER = 4'(CONV_ITERS);

    state_t             state_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [3:0]         cnt_q;
    logic               bad_q;
    logic [OUT_W-1:0]   data_q;
    logic               overflow_q;
    logic               invalid_q;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_adj;

    // One reverse double-dabble step: shift {bcd,bin} right, then fix nibbles.
    assign shifted = {bcd_q, bin_q} >> 1;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nibble   (shifted[BIN_W + 4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Control FSM plus datapath and result registers.
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, exactly like the flops they become.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_q   <= {hundreds, tens, units};
                        bin_q   <= '0;
                        cnt_q   <= '0;
                        bad_q   <= digits_invalid({hundreds, tens, units});
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bad_q) begin
                        // Bad digits: no iterations, report invalid right away.
                        data_q     <= '0;
                        overflow_q <= 1'b0;
                        invalid_q  <= 1'b1;
                        state_q    <= DONE;
                    end else if (cnt_q != LAST_ITER) begin
                        bcd_q <= bcd_adj;
                        bin_q <= shifted[BIN_W-1:0];
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        data_q     <= bin_q[OUT_W-1:0];
                        overflow_q <= (bin_q >> OUT_W) != '0;
                        invalid_q  <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data     = data_q;
    assign overflow = overflow_q;
    assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed corner cases,
// exhaustive 0..255 round trip and random digits against a decimal model.
module tb_bcd_to_binary_seq;

    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       hundreds, tens, units;
    logic             busy, done;
    logic [OUT_W-1:0] data;
    logic             overflow, invalid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_to_binary_seq #(.OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units),
        .busy     (busy),
        .done     (done),
        .data     (data),
        .overflow (overflow),
        .invalid  (invalid)
    );

    // Decimal reference: value = 100h + 10t + u, truncated to OUT_W bits.
    task automatic model(input int h, input int t, input int u,
                         output logic [OUT_W-1:0] d, output logic o, output logic inv);
        int v;
        if (h > 9 || t > 9 || u > 9) begin
            d = '0; o = 1'b0; inv = 1'b1;
        end else begin
            v   = 100 * h + 10 * t + u;
            d   = OUT_W'(v % (1 << OUT_W));
            o   = (v >= (1 << OUT_W));
            inv = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start from IDLE and wait (bounded) for done. lat is the edge
    // count from the accepting edge to done, -1 on timeout. stable drops if
    // any result output moved before done.
    task automatic do_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                           output int lat, output logic stable);
        logic [OUT_W-1:0] d0;
        logic o0, i0;
        d0 = data; o0 = overflow; i0 = invalid;
        hundreds = h; tens = t; units = u; start = 1'b1;
        step();
        start  = 1'b0;
        lat    = -1;
        stable = 1'b1;
        if (data !== d0 || overflow !== o0 || invalid !== i0) stable = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
            if (data !== d0 || overflow !== o0 || invalid !== i0) stable = 1'b0;
        end
    endtask

    // Compare everything visible in the done cycle against the model.
    task automatic check_result(input string name, input logic [3:0] h, input logic [3:0] t,
                                input logic [3:0] u, input int lat, input logic stable);
        logic [OUT_W-1:0] ed;
        logic eo, ei;
        int   elat;
        model(int'(h), int'(t), int'(u), ed, eo, ei);
        elat = ei ? 1 : 11;
        n_checks++;
        if (lat !== elat || data !== ed || overflow !== eo || invalid !== ei || !stable) begin
            n_errors++;
            $display("FAIL %s digits=%0d,%0d,%0d: got lat=%0d data=%0d ovf=%0b inv=%0b stable=%0b expected lat=%0d data=%0d ovf=%0b inv=%0b stable=1",
                     name, h, t, u, lat, data, overflow, invalid, stable, elat, ed, eo, ei);
        end
    endtask

    // After the done cycle the block must be idle with results held.
    task automatic check_after_done(input string name, input logic [OUT_W-1:0] ed);
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || data !== ed) begin
            n_errors++;
            $display("FAIL %s after done: got done=%0b busy=%0b data=%0d expected done=0 busy=0 data=%0d",
                     name, done, busy, data, ed);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        hundreds = 4'd2; tens = 4'd5; units = 4'd5;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== '0 || overflow !== 1'b0 || invalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b data=%0d ovf=%0b inv=%0b expected all 0",
                     busy, done, data, overflow, invalid);
        end
        rst = 1'b0; start = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_drops_start: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_known();
        logic [3:0] tbl [6][3] = '{'{2, 5, 5}, '{9, 9, 9}, '{0, 0, 0},
                                   '{1, 0, 0}, '{2, 5, 6}, '{0, 0, 9}};
        logic [OUT_W-1:0] ed;
        logic eo, ei, st;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_conv(tbl[i][0], tbl[i][1], tbl[i][2], lat, st);
            check_result("known", tbl[i][0], tbl[i][1], tbl[i][2], lat, st);
            model(int'(tbl[i][0]), int'(tbl[i][1]), int'(tbl[i][2]), ed, eo, ei);
            check_after_done("known", ed);
        end
    endtask

    task automatic test_invalid();
        logic [3:0] tbl [3][3] = '{'{0, 0, 10}, '{12, 3, 4}, '{15, 15, 15}};
        logic st;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_conv(tbl[i][0], tbl[i][1], tbl[i][2], lat, st);
            check_result("invalid", tbl[i][0], tbl[i][1], tbl[i][2], lat, st);
            check_after_done("invalid", '0);
        end
    endtask

    task automatic test_start_during_shift();
        int n_done = 0;
        logic [OUT_W-1:0] first_data = '0;
        hundreds = 4'd1; tens = 4'd2; units = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        hundreds = 4'd9; tens = 4'd9; units = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (done) begin
                if (n_done == 0) first_data = data;
                n_done++;
            end
            step();
        end
        n_checks++;
        if (n_done !== 1 || first_data !== 8'd123 || data !== 8'd123) begin
            n_errors++;
            $display("FAIL start_during_shift: got dones=%0d data=%0d/%0d expected dones=1 data=123",
                     n_done, first_data, data);
        end
    endtask

    task automatic test_start_on_done();
        logic st;
        int lat;
        do_conv(4'd0, 4'd4, 4'd2, lat, st);
        check_result("pre_done_start", 4'd0, 4'd4, 4'd2, lat, st);
        hundreds = 4'd7; tens = 4'd7; units = 4'd7; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== 8'd42) begin
            n_errors++;
            $display("FAIL start_on_done: got busy=%0b done=%0b data=%0d expected busy=0 done=0 data=42",
                     busy, done, data);
        end
    endtask

    task automatic test_reset_mid_shift();
        int n_done = 0;
        logic st;
        int lat;
        hundreds = 4'd3; tens = 4'd4; units = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 5; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== '0 || overflow !== 1'b0 || invalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_shift: got busy=%0b done=%0b data=%0d ovf=%0b inv=%0b expected all 0",
                     busy, done, data, overflow, invalid);
        end
        for (int n = 0; n < 15; n++) begin
            if (done) n_done++;
            step();
        end
        n_checks++;
        if (n_done !== 0) begin
            n_errors++;
            $display("FAIL reset_no_done: got dones=%0d expected 0", n_done);
        end
        do_conv(4'd1, 4'd7, 4'd8, lat, st);
        check_result("after_reset", 4'd1, 4'd7, 4'd8, lat, st);
        check_after_done("after_reset", 8'd178);
    endtask

    // Binary -> BCD in the bench, then back through the DUT.
    task automatic test_roundtrip();
        logic st;
        int lat;
        logic [3:0] h, t, u;
        for (int v = 0; v < 256; v++) begin
            h = 4'(v / 100);
            t = 4'((v / 10) % 10);
            u = 4'(v % 10);
            do_conv(h, t, u, lat, st);
            n_checks++;
            if (lat !== 11 || data !== OUT_W'(v) || overflow !== 1'b0 || invalid !== 1'b0 || !st) begin
                n_errors++;
                $display("FAIL roundtrip v=%0d: got lat=%0d data=%0d ovf=%0b inv=%0b stable=%0b expected lat=11 data=%0d ovf=0 inv=0 stable=1",
                         v, lat, data, overflow, invalid, st, v);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic st;
        int lat;
        logic [3:0] h, t, u;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                h = 4'($urandom_range(0, 9));
                t = 4'($urandom_range(0, 9));
                u = 4'($urandom_range(0, 9));
            end else begin
                h = 4'($urandom_range(0, 15));
                t = 4'($urandom_range(0, 15));
                u = 4'($urandom_range(0, 15));
            end
            do_conv(h, t, u, lat, st);
            check_result("random", h, t, u, lat, st);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        hundreds = '0; tens = '0; units = '0;
        step();
        step();
        test_reset();
        test_known();
        test_invalid();
        test_start_during_shift();
        test_start_on_done();
        test_reset_mid_shift();
        test_roundtrip();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_seq.md
BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001 SHALL have parameter: OUT_W, default 8, width of data output (legal range 1..10); overflow flags any value of 2^OUT_W or more.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to convert; sampled on the clk edge.
REQ-005 SHALL have port: hundreds  input  4  BCD hundreds digit.
REQ-006 SHALL have port: tens  input  4  BCD tens digit.
REQ-007 SHALL have port: units  input  4  BCD units digit.
REQ-008 SHALL have port: busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: data  output  OUT_W  converted binary value (low OUT_W bits).
REQ-011 SHALL have port: overflow  output  1  value does not fit in OUT_W bits.
REQ-012 SHALL have port: invalid  output  1  at least one input digit was greater than 9.

Function
REQ-013 SHALL implement the states IDLE, SHIFT and DONE: IDLE goes to SHIFT on a valid start; SHIFT goes to DONE after the 10th iteration; DONE goes to IDLE after one cycle.
REQ-014 SHALL accept start only when busy=0; start while busy=1 is ignored and the inputs are not resampled.
REQ-015 SHALL capture hundreds, tens and units into a 12-bit BCD register and clear a 10-bit binary register on the accepting edge.
REQ-016 SHALL, if any captured digit is greater than 9, go directly to DONE (skipping SHIFT) with invalid=1, data=0 and overflow=0.
REQ-017 SHALL, on each SHIFT iteration, shift the 22-bit concatenation {bcd,bin} right by one bit, then subtract 3 from every BCD nibble that is 8 or more; each iteration is one cycle and the iteration count is exactly 10.
REQ-018 SHALL, at the end of SHIFT, set data to bin[OUT_W-1:0], overflow to (bin ≥ 2^OUT_W) and invalid to 0.
REQ-019 SHALL assert done for exactly one cycle (the DONE state); for a valid start, done rises 11 edges after the accepting edge; for an invalid start, 1 edge after.
REQ-020 SHALL hold data, overflow and invalid stable from done until the next accepted start completes; they SHALL NOT change during SHIFT.
REQ-021 SHALL give a start in the same cycle as done no effect; the earliest acceptance is the first cycle back in IDLE.
REQ-022 SHALL use a 4-bit iteration counter that does not wrap; it is reloaded on every accepted start.

Reset
REQ-023 SHALL, when rst=1 at a clk edge, force state IDLE, counter 0, busy=0, done=0, data=0, overflow=0 and invalid=0, regardless of state.
REQ-024 SHALL let rst take priority over a simultaneous start; the start is dropped.
REQ-025 SHALL, on reset mid-SHIFT, abandon the conversion with no done pulse and leave no partial data visible.

Structure
REQ-026 SHALL place in shared package aes_display_pkg: the state enum (IDLE/SHIFT/DONE), BCD_DIGITS=3, CONV_ITERS=10 and BIN_W=10.
REQ-027 SHALL use one sub-module, bcd_nibble_adjust, a combinational 4-bit "subtract 3 if 8 or more" cell instantiated three times.

Verification
REQ-028 SHALL cover: digits 2,5,5 with start -> done 11 cycles later, data=255 (8'hFF), overflow=0, invalid=0.
REQ-029 SHALL cover: digits 9,9,9 -> data=231 (8'hE7), overflow=1; digits 0,0,0 -> data=0, overflow=0.
REQ-030 SHALL cover: units=10 (4'hA) -> done 1 cycle after start, invalid=1, data=0; start pulsed during SHIFT -> ignored, the first result is unchanged and only one done occurs.
REQ-031 SHALL cover: rst asserted at iteration 5 -> busy=0 the next cycle, done never pulses, all outputs 0; a new start then completes normally.
REQ-032 SHALL cover: exhaustive round trip, every value 0..255 passed through BCD_converter into this block -> data equals the original value, overflow=0 in all 256 cases.
